// File: rtl/float_div.sv
// rtl/float_div.sv - sequential binary16 divider, restoring mantissa division
//
// Purpose: result = a / b on IEEE-754 half precision, one quotient bit per
// clock. Denormals flush to zero, rounding is truncation.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, a, b         request and operands, accepted only in IDLE
//   busy, done          busy while dividing, done is a one-cycle pulse
//   result              quotient, held until the next accepted start
//   div_by_zero, overflow, underflow, invalid   status flags, valid with done

module float_div #(
    parameter int EXP_BIAS = 15,
    parameter int QBITS    = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        div_by_zero,
    output logic        overflow,
    output logic        underflow,
    output logic        invalid
);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_DONE} state_t;

    // special-case outcome decided at capture, applied in NORM
    localparam logic [1:0] SP_NONE  = 2'd0;
    localparam logic [1:0] SP_INV   = 2'd1;
    localparam logic [1:0] SP_DBZ   = 2'd2;
    localparam logic [1:0] SP_AZERO = 2'd3;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_sign;
    logic signed [6:0]  r_exp;
    logic [11:0]        r_rem;
    logic [10:0]        r_div;
    logic [QBITS-1:0]   r_quo;
    logic [3:0]         r_cnt;
    logic [1:0]         r_spec;
    logic [15:0]        r_result;
    logic               r_dbz;
    logic               r_ovf;
    logic               r_unf;
    logic               r_inv;

    logic               w_a_zero;
    logic               w_b_zero;
    logic               w_any_inf;
    logic [1:0]         w_spec;
    logic signed [6:0]  w_exp_diff;
    logic               w_ge;
    logic [10:0]        w_sub;
    logic signed [6:0]  w_exp_adj;
    logic [9:0]         w_mant;

    // operand classification at capture
    assign w_a_zero   = (a[14:10] == 5'd0);
    assign w_b_zero   = (b[14:10] == 5'd0);
    assign w_any_inf  = (a[14:10] == 5'h1F) || (b[14:10] == 5'h1F);
    assign w_exp_diff = $signed({2'b00, a[14:10]}) - $signed({2'b00, b[14:10]})
                        + $signed(7'(EXP_BIAS));

    always_comb begin
        w_spec = SP_NONE;
        if (w_any_inf || (w_a_zero && w_b_zero)) w_spec = SP_INV;
        else if (w_b_zero)                       w_spec = SP_DBZ;
        else if (w_a_zero)                       w_spec = SP_AZERO;
    end

    // one restoring step; the partial remainder always stays below 2*d,
    // so the difference fits in 11 bits before the shift
    assign w_ge  = (r_rem >= {1'b0, r_div});
    assign w_sub = w_ge ? 11'(r_rem - {1'b0, r_div}) : r_rem[10:0];

    // quotient lies in [0.5, 2): either the integer bit is set or the
    // first fraction bit is, so at most one position of shift is needed
    assign w_exp_adj = r_quo[QBITS-1] ? r_exp : (r_exp - 7'sd1);
    assign w_mant    = r_quo[QBITS-1] ? r_quo[QBITS-2 -: 10] : r_quo[QBITS-3 -: 10];

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (start) w_next_state = S_DIV;
            S_DIV:  if (r_cnt == 4'(QBITS - 1)) w_next_state = S_NORM;
            S_NORM: w_next_state = S_DONE;
            S_DONE: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // handshake outputs
    always_comb begin
        busy = (r_state == S_DIV) || (r_state == S_NORM);
        done = (r_state == S_DONE);
    end

    // datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sign   <= 1'b0;
            r_exp    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_quo    <= '0;
            r_cnt    <= '0;
            r_spec   <= SP_NONE;
            r_result <= 16'h0000;
            r_dbz    <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_inv    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_sign <= a[15] ^ b[15];
                    r_exp  <= w_exp_diff;
                    r_rem  <= {2'b01, a[9:0]};
                    r_div  <= {1'b1, b[9:0]};
                    r_quo  <= '0;
                    r_cnt  <= '0;
                    r_spec <= w_spec;
                    r_dbz  <= 1'b0;
                    r_ovf  <= 1'b0;
                    r_unf  <= 1'b0;
                    r_inv  <= 1'b0;
                end
                S_DIV: begin
                    r_rem <= {w_sub, 1'b0};
                    r_quo <= {r_quo[QBITS-2:0], w_ge};
                    r_cnt <= r_cnt + 4'd1;
                end
                S_NORM: begin
                    case (r_spec)
                        SP_INV: begin
                            r_result <= 16'h7E00;
                            r_inv    <= 1'b1;
                        end
                        SP_DBZ: begin
                            r_result <= {r_sign, 5'h1F, 10'h000};
                            r_dbz    <= 1'b1;
                        end
                        SP_AZERO: r_result <= {r_sign, 15'h0000};
                        default: begin
                            if (w_exp_adj >= 7'sd31) begin
                                r_result <= {r_sign, 5'h1F, 10'h000};
                                r_ovf    <= 1'b1;
                            end else if (w_exp_adj <= 7'sd0) begin
                                r_result <= {r_sign, 15'h0000};
                                r_unf    <= 1'b1;
                            end else begin
                                r_result <= {r_sign, w_exp_adj[4:0], w_mant};
                            end
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign result      = r_result;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;
    assign underflow   = r_unf;
    assign invalid     = r_inv;

endmodule

// File: tb/tb_float_div.sv
// tb/tb_float_div.sv - self-checking bench for float_div

module tb_float_div;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        div_by_zero;
    logic        overflow;
    logic        underflow;
    logic        invalid;
    logic [3:0]  flags;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] last_res;

    always #5 clk = ~clk;

    assign flags = {div_by_zero, overflow, underflow, invalid};

    float_div dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .underflow   (underflow),
        .invalid     (invalid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference: {result, dbz, ovf, unf, inv} from plain integer arithmetic
    function automatic logic [19:0] ref_div(input logic [15:0] x, input logic [15:0] y);
        int          ea, eb, e, ma, mb, q;
        logic        s;
        logic [9:0]  m;
        ea = int'(x[14:10]);
        eb = int'(y[14:10]);
        s  = x[15] ^ y[15];
        if (ea == 31 || eb == 31 || (ea == 0 && eb == 0)) return {16'h7E00, 4'b0001};
        if (eb == 0) return {s, 5'h1F, 10'h000, 4'b1000};
        if (ea == 0) return {s, 15'h0000, 4'b0000};
        ma = 1024 + int'(x[9:0]);
        mb = 1024 + int'(y[9:0]);
        q  = (ma * 2048) / mb;
        e  = ea - eb + 15;
        if (q < 2048) begin
            e = e - 1;
            m = 10'(q % 1024);
        end else begin
            m = 10'((q / 2) % 1024);
        end
        if (e >= 31) return {s, 5'h1F, 10'h000, 4'b0100};
        if (e <= 0)  return {s, 15'h0000, 4'b0010};
        return {s, 5'(e), m, 4'b0000};
    endfunction

    function automatic logic [15:0] rnd_operand();
        logic [15:0] v;
        v = 16'($urandom);
        if ($urandom_range(0, 9) == 0) v[14:10] = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'h1F;
        else                           v[14:10] = 5'($urandom_range(1, 30));
        return v;
    endfunction

    // start sampled at the edge this task waits on; returns #1 after it
    task automatic launch(input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_div(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] er, input logic [3:0] ef);
        int cyc;
        int bc;
        launch(x, y);
        chk({tag, "_flags_clr"}, 32'(flags), 32'd0);
        chk({tag, "_res_hold"}, 32'(result), 32'(last_res));
        bc  = int'(busy);
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            bc += int'(busy);
        end
        chk({tag, "_latency"}, 32'(cyc), 32'd13);
        chk({tag, "_busy_cycles"}, 32'(bc), 32'd13);
        chk({tag, "_res"}, 32'(result), 32'(er));
        chk({tag, "_flags"}, 32'(flags), 32'(ef));
        last_res = er;
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_res_stable"}, 32'(result), 32'(er));
    endtask

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] r;
        logic [3:0]  f;
    } vec_t;

    vec_t vecs[9] = '{
        '{16'h3C00, 16'h3C00, 16'h3C00, 4'b0000},
        '{16'h4600, 16'h4000, 16'h4200, 4'b0000},
        '{16'hC000, 16'h3800, 16'hC400, 4'b0000},
        '{16'h3C00, 16'h4200, 16'h3555, 4'b0000},
        '{16'h3C00, 16'h0000, 16'h7C00, 4'b1000},
        '{16'h0000, 16'h0000, 16'h7E00, 4'b0001},
        '{16'h7C00, 16'h3C00, 16'h7E00, 4'b0001},
        '{16'h7BFF, 16'h1400, 16'h7C00, 4'b0100},
        '{16'h0400, 16'h7800, 16'h0000, 4'b0010}
    };

    initial begin
        logic [19:0] exp_v;
        logic [15:0] x;
        logic [15:0] y;
        int          n;

        rst_n    = 1'b0;
        start    = 1'b0;
        a        = 16'h0;
        b        = 16'h0;
        last_res = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'h0000);
        chk("rst_flags", 32'(flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) do_div($sformatf("dir%0d", i), vecs[i].x, vecs[i].y, vecs[i].r, vecs[i].f);

        // start during DIV is ignored
        launch(16'h3C00, 16'h4200);
        repeat (4) @(posedge clk);
        @(negedge clk);
        a     = 16'h7BFF;
        b     = 16'h1400;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ign_done_seen", 32'(done), 32'd1);
        chk("ign_res", 32'(result), 32'h3555);
        chk("ign_flags", 32'(flags), 32'd0);
        last_res = 16'h3555;
        @(posedge clk);
        #1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("ign_no_restart", 32'(busy), 32'd0);
        end

        // reset in the middle of DIV aborts with no done pulse
        launch(16'h4600, 16'h4000);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'(result), 32'h0000);
        @(negedge clk);
        rst_n    = 1'b1;
        last_res = 16'h0000;
        n = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            n += int'(done);
        end
        chk("abort_no_done", 32'(n), 32'd0);
        do_div("post_abort", 16'h4600, 16'h4000, 16'h4200, 4'b0000);

        // randomized operands against the reference
        for (int k = 0; k < 150; k++) begin
            x     = rnd_operand();
            y     = rnd_operand();
            exp_v = ref_div(x, y);
            do_div($sformatf("rnd_%h_%h", x, y), x, y, exp_v[19:4], exp_v[3:0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
